// File: rtl/ddr3_pkg.sv
// Shared types and constants for the DDR3 read-data gather path.
package ddr3_pkg;

    localparam int BEATS_PER_BURST = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GATHER
    } gather_state_t;

    function automatic int burst_width(input int lanes);
        return lanes * BEATS_PER_BURST;
    endfunction

endpackage

// File: rtl/ddr3_rdata_gather_if.sv
// User-side burst port: head burst plus valid/ready handshake.
interface ddr3_rdata_gather_if
    import ddr3_pkg::*;
#(
    parameter int D_BUS_WIDTH = 16
);
    logic [D_BUS_WIDTH*BEATS_PER_BURST-1:0] rd_data;
    logic                                   rd_valid;
    logic                                   rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/ddr3_rdata_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module ddr3_rdata_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Gating with empty keeps rd_data at zero through and after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide
    // which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/ddr3_rdata_gather.sv
// Gathers per-lane 8-beat read bursts into whole bursts and buffers them.
// Optional gather timeout enabled by defining DDR3_RDATA_TIMEOUT_EN.
module ddr3_rdata_gather
    import ddr3_pkg::*;
#(
    parameter int D_BUS_WIDTH     = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 32
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [D_BUS_WIDTH-1:0]                      lane_ready,
    input  logic [D_BUS_WIDTH*BEATS_PER_BURST-1:0]      pdata_in,
    input  logic                                        rd_expect,
    input  logic                                        err_clr,
    output logic                                        overflow_err,
    output logic                                        unexpected_err,
    output logic                                        timeout_err,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]        outstanding,
    ddr3_rdata_gather_if.master                         rd_if
);
    localparam int BW = burst_width(D_BUS_WIDTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    gather_state_t                state, state_next;
    logic [D_BUS_WIDTH-1:0]       sticky, sticky_next;
    logic [BEATS_PER_BURST-1:0]   hold [D_BUS_WIDTH];
    logic [BW-1:0]                burst_data, fifo_rd_data;
    logic [OW-1:0]                outstanding_next;
    logic complete, have_pending, expect_ok, push, pop;
    logic fifo_full, fifo_empty, timeout_fire;
    logic overflow_set, unexpected_set;

    assign complete     = &(sticky | lane_ready);
    assign have_pending = (outstanding != '0);
    assign expect_ok    = rd_expect && (outstanding != OW'(MAX_OUTSTANDING));
    assign push         = complete && have_pending;
    assign pop          = rd_if.rd_valid && rd_if.rd_ready;

    assign overflow_set   = push && fifo_full && !pop;
    assign unexpected_set = (complete && !have_pending) || (rd_expect && !expect_ok);

    // Lanes pulsing in the completing cycle bypass their holding register.
    always_comb begin
        burst_data = '0;
        for (int n = 0; n < D_BUS_WIDTH; n++) begin
            for (int b = 0; b < BEATS_PER_BURST; b++) begin
                burst_data[n + D_BUS_WIDTH*b] = lane_ready[n] ? pdata_in[n + D_BUS_WIDTH*b]
                                                              : hold[n][b];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < D_BUS_WIDTH; n++) begin
            if (lane_ready[n]) begin
                for (int b = 0; b < BEATS_PER_BURST; b++) begin
                    hold[n][b] <= pdata_in[n + D_BUS_WIDTH*b];
                end
            end
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the case can leave a latch behind.
        sticky_next      = sticky | lane_ready;
        outstanding_next = outstanding + OW'(expect_ok) - OW'(push || timeout_fire);
        state_next       = state;
        if (complete || timeout_fire) sticky_next = '0;
        case (state)
            IDLE: begin
                if (outstanding_next != '0) state_next = (|sticky_next) ? GATHER : WAIT;
            end
            WAIT, GATHER: begin
                if (outstanding_next == '0) state_next = IDLE;
                else if (|sticky_next)      state_next = GATHER;
                else                        state_next = WAIT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sticky         <= '0;
            outstanding    <= '0;
            overflow_err   <= 1'b0;
            unexpected_err <= 1'b0;
        end else begin
            state          <= state_next;
            sticky         <= sticky_next;
            outstanding    <= outstanding_next;
            overflow_err   <= overflow_set   | (overflow_err   & ~err_clr);
            unexpected_err <= unexpected_set | (unexpected_err & ~err_clr);
        end
    end

`ifdef DDR3_RDATA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    assign timeout_fire = (state != IDLE) && have_pending && !complete
                          && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_next != state || complete || timeout_fire) tmo_cnt <= '0;
            else if (state != IDLE)                               tmo_cnt <= tmo_cnt + 1'b1;
            timeout_err <= timeout_fire | (timeout_err & ~err_clr);
        end
    end
`else
    // Without the timeout a partial gather waits forever; the comparison is
    // constant-false for any legal TIMEOUT_CYCLES.
    assign timeout_fire = (TIMEOUT_CYCLES < 0);
    assign timeout_err  = 1'b0;
`endif

    ddr3_rdata_fifo #(
        .WIDTH (BW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (burst_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd_if.rd_data  = fifo_rd_data;
    assign rd_if.rd_valid = !fifo_empty;
endmodule
